// File: rtl/grf_pkg.sv
// Shared GRF constants and the dump-reader state encoding.
package grf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        SUM  = 3'd3,
        DONE = 3'd4
    } dump_state_t;

endpackage

// File: rtl/grf_dump_reader.sv
// GRF debug read-out: walks [first_idx..last_idx] through one GRF read port and streams (index, value) beats.
// Optional XOR checksum trailer beat when GRF_DUMP_CHECKSUM_EN is defined.
module grf_dump_reader
    import grf_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_idx,
    input  logic [ADDR_W-1:0] last_idx,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_is_sum,
    output logic              busy,
    output logic              done
);

`ifdef GRF_DUMP_CHECKSUM_EN
    localparam dump_state_t AFTER_LAST_REG = SUM;
    localparam logic        LAST_ON_REG    = 1'b0;
`else
    localparam dump_state_t AFTER_LAST_REG = DONE;
    localparam logic        LAST_ON_REG    = 1'b1;
`endif

    dump_state_t       r_state;
    dump_state_t       w_state_nxt;

    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_out_idx;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_busy;

    logic              w_start_acc;
    logic              w_hs;
    logic              w_last_reg;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_hs        = r_out_valid && out_ready;
    // The address only advances after a non-final handshake, so it never passes r_last.
    assign w_last_reg  = (r_rd_addr == r_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (first_idx <= last_idx) ? LOAD : DONE;
                end
            end
            LOAD: w_state_nxt = SEND;
            SEND: begin
                if (w_hs) begin
                    w_state_nxt = w_last_reg ? AFTER_LAST_REG : LOAD;
                end
            end
            SUM: begin
                if (w_hs) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef GRF_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_acc;
    logic              r_out_is_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_start_acc) begin
            r_acc <= '0;
        end else if ((r_state == SEND) && w_hs) begin
            r_acc <= r_acc ^ r_out_data;
        end
    end

    assign out_is_sum = r_out_is_sum;
`else
    assign out_is_sum = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last      <= '0;
            r_rd_addr   <= '0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
`ifdef GRF_DUMP_CHECKSUM_EN
            r_out_is_sum <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_acc) begin
                        r_last    <= last_idx;
                        r_rd_addr <= first_idx;
                        r_busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    // BUSA is sampled here; later GRF writes cannot touch this beat.
                    r_out_data  <= rd_data;
                    r_out_idx   <= r_rd_addr;
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_last_reg && LAST_ON_REG;
`ifdef GRF_DUMP_CHECKSUM_EN
                    r_out_is_sum <= 1'b0;
`endif
                end
                SEND: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                        if (!w_last_reg) begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                        end
`ifdef GRF_DUMP_CHECKSUM_EN
                        else begin
                            r_out_valid  <= 1'b1;
                            r_out_data   <= r_acc ^ r_out_data;
                            r_out_idx    <= '0;
                            r_out_last   <= 1'b1;
                            r_out_is_sum <= 1'b1;
                        end
`endif
                    end
                end
`ifdef GRF_DUMP_CHECKSUM_EN
                SUM: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_addr   = r_rd_addr;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_grf_dump_reader.sv
// Bench for grf_dump_reader: GRF array model, table-driven range dumps, corner sequences and random dumps.
module tb_grf_dump_reader;

`ifdef GRF_DUMP_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_is_sum;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    grf_dump_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_is_sum(out_is_sum),
        .busy      (busy),
        .done      (done)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
        logic        is_sum;
    } beat_t;

    typedef struct {
        logic [4:0] f;
        logic [4:0] l;
        int         n;
        int         done_cyc;
    } vec_t;

    beat_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected beat list: every register in range in order, then optional XOR trailer.
    function automatic void build_exp(input logic [4:0] f, input logic [4:0] l);
        logic [31:0] acc;
        acc = '0;
        exp_q.delete();
        if (f <= l) begin
            for (int i = int'(f); i <= int'(l); i++) begin
                exp_q.push_back('{idx: 5'(i), data: regs[i], last: (i == int'(l)) && !CS, is_sum: 1'b0});
                acc ^= regs[i];
            end
            if (CS) exp_q.push_back('{idx: 5'd0, data: acc, last: 1'b1, is_sum: 1'b1});
        end
    endfunction

    function automatic void fix_sum();
        logic [31:0] acc;
        acc = '0;
        foreach (exp_q[i]) if (!exp_q[i].is_sum) acc ^= exp_q[i].data;
        foreach (exp_q[i]) if (exp_q[i].is_sum) exp_q[i].data = acc;
    endfunction

    task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int stall_pct,
                           input int stall_first, input bit do_wr, input logic [4:0] wr_idx,
                           input logic [31:0] wr_val, input bit poke_start,
                           output int done_cyc, output int nbeats);
        int          c;
        int          first_stalls;
        bit          have_hold;
        bit          wrote;
        bit          rdy;
        logic [4:0]  h_idx;
        logic [31:0] h_data;
        beat_t       b;
        beat_t       keep;
        build_exp(f, l);
        done_cyc = -1;
        nbeats = 0;
        first_stalls = 0;
        have_hold = 0;
        wrote = 0;
        @(negedge clk);
        start = 1'b1; first_idx = f; last_idx = l; out_ready = 1'b0;
        @(posedge clk);
        c = 1;
        while (c < 400) begin
            @(negedge clk);
            start = 1'b0;
            if (poke_start && ($urandom_range(0, 1) == 1)) begin
                start = 1'b1; first_idx = 5'($urandom); last_idx = 5'($urandom);
            end
            chk("busy_during_dump", 64'(busy), 64'd1);
            if (done) begin
                start = 1'b0;
                done_cyc = c;
                chk("rd_addr_at_done", 64'(rd_addr), 64'((f <= l) ? l : f));
                break;
            end
            if (have_hold) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_idx", 64'(out_idx), 64'(h_idx));
                chk("stall_data", 64'(out_data), 64'(h_data));
            end
            if (do_wr && !wrote && out_valid) begin
                regs[wr_idx] = wr_val;
                keep = exp_q[0];
                build_exp(f, l);
                exp_q[0] = keep;
                fix_sum();
                wrote = 1;
            end
            if (out_valid && first_stalls < stall_first) begin
                rdy = 1'b0;
                first_stalls++;
            end else begin
                rdy = ($urandom_range(0, 99) >= stall_pct);
            end
            out_ready = rdy;
            have_hold = 0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(out_valid), 64'd0);
                end else if (rdy) begin
                    b = exp_q.pop_front();
                    nbeats++;
                    chk("beat_idx", 64'(out_idx), 64'(b.idx));
                    chk("beat_data", 64'(out_data), 64'(b.data));
                    chk("beat_last", 64'(out_last), 64'(b.last));
                    chk("beat_is_sum", 64'(out_is_sum), 64'(b.is_sum));
                end else begin
                    have_hold = 1; h_idx = out_idx; h_data = out_data;
                end
            end
            @(posedge clk);
            c++;
        end
        chk("done_seen", 64'(done_cyc >= 0), 64'd1);
        chk("beats_left", 64'(exp_q.size()), 64'd0);
        out_ready = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("after_busy", 64'(busy), 64'd0);
        chk("after_done", 64'(done), 64'd0);
        chk("after_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_idx"}, 64'(out_idx), 64'd0);
        chk({tag, "_data"}, 64'(out_data), 64'd0);
        chk({tag, "_last"}, 64'(out_last), 64'd0);
        chk({tag, "_is_sum"}, 64'(out_is_sum), 64'd0);
        chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[1] = 32'h4; regs[2] = 32'h8; regs[31] = 32'h1;
    endtask

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dc;
        int nb;
        int ef;
        int el;
        tbl[0] = '{f: 5'd1,  l: 5'd2,  n: 2,  done_cyc: 5};
        tbl[1] = '{f: 5'd31, l: 5'd31, n: 1,  done_cyc: 3};
        tbl[2] = '{f: 5'd5,  l: 5'd3,  n: 0,  done_cyc: 1};
        tbl[3] = '{f: 5'd0,  l: 5'd0,  n: 1,  done_cyc: 3};
        tbl[4] = '{f: 5'd30, l: 5'd31, n: 2,  done_cyc: 5};
        tbl[5] = '{f: 5'd0,  l: 5'd31, n: 32, done_cyc: 65};

        preload();
        reset = 1'b1; start = 1'b0; first_idx = '0; last_idx = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        // Table: full-speed dumps with fixed expected beat count and done cycle.
        for (int k = 0; k < 6; k++) begin
            do_dump(tbl[k].f, tbl[k].l, 0, 0, 1'b0, 5'd0, 32'd0, 1'b0, dc, nb);
            chk($sformatf("tbl%0d_beats", k), 64'(nb), 64'(tbl[k].n + ((CS && tbl[k].n > 0) ? 1 : 0)));
            chk($sformatf("tbl%0d_done_cyc", k), 64'(dc),
                64'(tbl[k].done_cyc + ((CS && tbl[k].n > 0) ? 1 : 0)));
        end

        // First beat stalled 3 cycles; bench checks it is held stable.
        do_dump(5'd1, 5'd2, 0, 3, 1'b0, 5'd0, 32'd0, 1'b0, dc, nb);
        chk("stall3_done_cyc", 64'(dc), 64'(8 + (CS ? 1 : 0)));

        // GRF write to a not-yet-read register during the first SEND is seen.
        do_dump(5'd1, 5'd2, 0, 1, 1'b1, 5'd2, 32'h10, 1'b0, dc, nb);
        regs[2] = 32'h8;
        // Write to the register already captured must not change its beat.
        do_dump(5'd1, 5'd2, 0, 1, 1'b1, 5'd1, 32'hDEAD, 1'b0, dc, nb);
        regs[1] = 32'h4;

        // Reset while beat 1 is pending.
        @(negedge clk);
        start = 1'b1; first_idx = 5'd1; last_idx = 5'd2; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        chk("pre_reset_idx", 64'(out_idx), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("midreset");
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_done", 64'(done), 64'd0);
        chk("post_reset_busy", 64'(busy), 64'd0);
        do_dump(5'd1, 5'd2, 0, 0, 1'b0, 5'd0, 32'd0, 1'b0, dc, nb);
        chk("restart_done_cyc", 64'(dc), 64'(5 + (CS ? 1 : 0)));

        // Random ranges, random backpressure, start poked while busy.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            ef = $urandom_range(0, 31);
            if ($urandom_range(0, 4) == 0) el = $urandom_range(0, 31);
            else el = (ef + $urandom_range(0, 6) > 31) ? 31 : ef + $urandom_range(0, 6);
            do_dump(5'(ef), 5'(el), 30, $urandom_range(0, 2), 1'b0, 5'd0, 32'd0, 1'b1, dc, nb);
            chk("rand_beats", 64'(nb), 64'((ef <= el) ? (el - ef + 1 + (CS ? 1 : 0)) : 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
